// File: rtl/dmul_seq_pkg.sv
// Shared definitions for the sequential multiplier and the dALU it drives:
// ALU opcodes, flag bit positions, FSM states and the fixed operand width.
package dmul_seq_pkg;

    localparam int WIDTH       = 16;
    localparam int CNT_W       = 5;
    localparam int FLAGS_W     = 2;
    localparam int FLAGS_ZERO  = 0;
    localparam int FLAGS_CARRY = 1;

    localparam logic [CNT_W-1:0] ITERATIONS = 5'd16;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_ADD  = 4'd5,
        OP_SHL  = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dALU.sv
// Datapath ALU subset used by the multiplier: pass-through, add and shift-left,
// with carry-out and zero flags.
module dALU
    import dmul_seq_pkg::*;
(
    input  alu_op_t             op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output logic [FLAGS_W-1:0]  flags
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_PASS: wide = {1'b0, a};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SHL:  wide = {a, 1'b0};
            default: wide = '0;
        endcase
    end

    always_comb begin
        result             = wide[WIDTH-1:0];
        flags              = '0;
        flags[FLAGS_CARRY] = wide[WIDTH];
        flags[FLAGS_ZERO]  = (wide[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/dmul_seq.sv
// Shift-and-add 16x16 unsigned multiplier sequencing one dALU through CALC/SHIFT
// pairs. Define DMUL_EARLY_EXIT_EN to stop as soon as the multiplier runs out of set bits.
module dmul_seq
    import dmul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_prod,
    output logic              out_ovf,
    output logic              out_zero
);

    state_t             state_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   p_reg;
    logic               ovf_reg;
    logic [CNT_W-1:0]   cnt_reg;

    alu_op_t            alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_y;
    logic [FLAGS_W-1:0] alu_flags;
    logic               alu_carry;
    logic               unused_alu_zero;

    logic [WIDTH-1:0]   q_shift;
    logic [CNT_W-1:0]   cnt_next;
    logic               shift_ovf;
    logic               shift_term;
    logic               idle_term;

    dALU u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_y),
        .flags  (alu_flags)
    );

    always_comb begin
        alu_op = OP_PASS;
        alu_a  = '0;
        alu_b  = '0;
        case (state_reg)
            CALC: begin
                alu_op = OP_ADD;
                alu_a  = p_reg;
                alu_b  = m_reg;
            end
            SHIFT: begin
                alu_op = OP_SHL;
                alu_a  = m_reg;
            end
            default: ;
        endcase
    end

    assign alu_carry       = alu_flags[FLAGS_CARRY];
    assign unused_alu_zero = alu_flags[FLAGS_ZERO];
    assign q_shift         = q_reg >> 1;
    assign cnt_next        = cnt_reg + 1'b1;
    // A multiplicand bit pushed out is only an overflow if a later multiplier bit would have used it.
    assign shift_ovf       = ovf_reg | (alu_carry & (q_shift != '0));

`ifdef DMUL_EARLY_EXIT_EN
    assign shift_term = (q_shift == '0);
    assign idle_term  = (in_b == '0);
`else
    assign shift_term = (cnt_next == ITERATIONS);
    assign idle_term  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            p_reg     <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_reg    <= in_a;
                        q_reg    <= in_b;
                        p_reg    <= '0;
                        ovf_reg  <= 1'b0;
                        cnt_reg  <= '0;
                        in_ready <= 1'b0;
                        if (idle_term) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            out_prod  <= '0;
                            out_ovf   <= 1'b0;
                            out_zero  <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (q_reg[0]) begin
                        p_reg   <= alu_y;
                        ovf_reg <= ovf_reg | alu_carry;
                    end
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    m_reg   <= alu_y;
                    q_reg   <= q_shift;
                    cnt_reg <= cnt_next;
                    ovf_reg <= shift_ovf;
                    if (shift_term) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        out_prod  <= p_reg;
                        out_ovf   <= shift_ovf;
                        out_zero  <= (p_reg == '0);
                    end else begin
                        state_reg <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
